multi_mode_ffreg: RTL and testbench
===================================

Name: multi_mode_ffreg

Overview:
- Parametrised register bank of WIDTH edge-triggered flip-flops. A per-cycle mode selects D, JK, T, SR, shift or rotate behaviour.
- Generalises the single-bit D-from-JK flop in the sequential-circuits library, which had one bit, one mode and a floating (z) reset.
- Sits in the flip-flop library as the common storage primitive for counters, shifters and small datapath registers.
- Adds enable, serial I/O, defined reset value and status pulses (illegal-input, changed).

Parameters:
- WIDTH, 8, number of flip-flop bits (≥2).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  update enable; 0 = hold all state.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  D data (mode 001) / toggle mask (mode 011).
- j  input  WIDTH  J inputs (mode 010) / S inputs (mode 100).
- k  input  WIDTH  K inputs (mode 010) / R inputs (mode 100).
- ser_in  input  1  serial input for shift modes.
- q  output  WIDTH  register state.
- qb  output  WIDTH  ~q, combinational from q.
- ser_out  output  1  registered: bit shifted or rotated out on the last enabled shift/rotate.
- illegal  output  1  registered 1-cycle pulse: SR mode with any bit S=R=1.
- changed  output  1  registered 1-cycle pulse: q differs from its pre-edge value.

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - q=RESET_VAL, qb=~RESET_VAL, ser_out=0, illegal=0, changed=0.
  - Never z or x.
- Release: state holds RESET_VAL until the first posedge with rst=1.
- Assert mid-operation: immediately overrides any pending update; no partial update is retained.
- en=0 at posedge: q and ser_out hold; illegal and changed are driven to 0.
- en=1 at posedge: next q by mode; latency 1 clock, so the new q is visible after the edge.
  - 000 hold: q unchanged.
  - 001 D: q=d.
  - 010 JK, per bit i, {j,k}: 00 hold, 01 clear, 10 set, 11 toggle.
  - 011 T: q = q ^ d.
  - 100 SR, per bit:
    - S=1,R=0 set; S=0,R=1 clear; 00 hold.
    - 11 holds that bit and sets illegal=1 for one cycle.
    - Legal bits in the same cycle still update.
  - 101 shift left: q = {q[WIDTH-2:0], ser_in}; ser_out = old q[WIDTH-1].
  - 110 shift right: q = {ser_in, q[WIDTH-1:1]}; ser_out = old q[0].
  - 111 rotate left: q = {q[WIDTH-2:0], q[WIDTH-1]}; ser_out = old q[WIDTH-1]; ser_in ignored.
- ser_out: updates only in modes 101/110/111 with en=1; otherwise holds.
- changed: 1 for exactly one cycle after an enabled edge where next q ≠ current q; else 0.
- illegal: only asserted in mode 100; 0 in every other mode.
- Pulses: illegal and changed may both be 1 in the same cycle.
- Unknown inputs: x/z on mode or data must not corrupt bits whose selected operation does not depend on them.
- Simulation only: assertion fires if mode is x while en=1.
- qb: always exactly ~q, including during reset.

Test Plan:
- Reset/enable, WIDTH=8, RESET_VAL=8'hA5: hold rst=0 across two clk edges → q=A5, qb=5A, flags 0. Release rst, en=0, mode=001, d=FF for 3 clocks → q stays A5, changed=0.
- D and JK: mode=001, d=3C → q=3C, changed=1. Next cycle mode=010, j=F0, k=0F → q = 3C updated per bit (set upper, clear lower) = F0. Repeat with j=k=FF → q=0F.
- T and no-change: q=0F, mode=011, d=00 → q=0F, changed=0. Then d=FF → q=F0, changed=1 for one cycle only.
- SR illegal: q=00, mode=100, j=81, k=01 → bit0 holds 0, bit7 sets → q=80, illegal=1 one cycle. Next cycle mode=000 → illegal=0.
- Shift/rotate: q=81.
  - mode=101, ser_in=0 → q=02, ser_out=1.
  - mode=110, ser_in=1 → q=81, ser_out=0.
  - mode=111 → q=03, ser_out=1.
  - Eight consecutive rotates return q to its start value.
- Async reset mid-operation: shift every cycle, then drop rst midway between edges → q=RESET_VAL immediately (before the next edge), ser_out=0, changed=0. After release, the first enabled edge resumes normal operation.

Source files
------------

// File: rtl/multi_mode_ffreg.sv
// multi_mode_ffreg: a bank of WIDTH flip-flops. A per-cycle mode selects
// hold, D, JK, T, SR, shift-left, shift-right or rotate-left behaviour.
// The block also has a serial output and registered illegal/changed pulses.
module multi_mode_ffreg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             ser_out,
  output logic             illegal,
  output logic             changed
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_D    = 3'b001;
  localparam logic [2:0] M_JK   = 3'b010;
  localparam logic [2:0] M_T    = 3'b011;
  localparam logic [2:0] M_SR   = 3'b100;
  localparam logic [2:0] M_SHL  = 3'b101;
  localparam logic [2:0] M_SHR  = 3'b110;
  localparam logic [2:0] M_ROL  = 3'b111;

  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_q, ser_d;
  logic             ill_q, ill_d;
  logic             chg_q, chg_d;

  // SR decode: S=R=1 is neither set nor clear, so that bit holds.
  logic [WIDTH-1:0] sr_set, sr_clr;
  assign sr_set = j & ~k;
  assign sr_clr = k & ~j;

  // Next-state selection. An unknown mode falls to the default and holds.
  // The per-bit forms keep unknown data confined to the bits that use it.
  always_comb begin
    q_d   = q_q;
    ser_d = ser_q;
    ill_d = 1'b0;
    chg_d = 1'b0;
    if (en) begin
      case (mode)
        M_HOLD: q_d = q_q;
        M_D:    q_d = d;
        M_JK:   q_d = (j & ~q_q) | (~k & q_q);
        M_T:    q_d = q_q ^ d;
        M_SR: begin
          q_d   = sr_set | (q_q & ~sr_clr);
          ill_d = |(j & k);
        end
        M_SHL: begin
          q_d   = {q_q[WIDTH-2:0], ser_in};
          ser_d = q_q[WIDTH-1];
        end
        M_SHR: begin
          q_d   = {ser_in, q_q[WIDTH-1:1]};
          ser_d = q_q[0];
        end
        M_ROL: begin
          q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          ser_d = q_q[WIDTH-1];
        end
        default: q_d = q_q;
      endcase
      chg_d = (q_d != q_q);
    end
  end

  // State and status registers. Reset asserts asynchronously and forces a defined value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= RESET_VAL;
      ser_q <= 1'b0;
      ill_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ser_q <= ser_d;
      ill_q <= ill_d;
      chg_q <= chg_d;
    end
  end

  assign q       = q_q;
  assign qb      = ~q_q;
  assign ser_out = ser_q;
  assign illegal = ill_q;
  assign changed = chg_q;

`ifndef SYNTHESIS
  // An enabled edge with an unknown mode would silently hold; flag it in simulation.
  mode_known_a: assert property (@(posedge clk) disable iff (!rst) en |-> !$isunknown(mode));
`endif

endmodule

// File: tb/tb_multi_mode_ffreg.sv
// Testbench for multi_mode_ffreg (WIDTH=8, RESET_VAL=8'hA5). Expected results
// go into a scoreboard queue when each cycle is driven. They are popped after the edge.
module tb_multi_mode_ffreg;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d, j, k;
  logic         ser_in;
  logic [W-1:0] q, qb;
  logic         ser_out, illegal, changed;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       en;
    logic [2:0] m;
    logic [7:0] d;
    logic [7:0] j;
    logic [7:0] k;
    logic       si;
    logic [7:0] q;
    logic       so;
    logic       il;
    logic       ch;
  } vec_t;

  typedef struct packed {
    logic [7:0] q;
    logic       so;
    logic       il;
    logic       ch;
  } exp_t;

  exp_t sb[$];

  multi_mode_ffreg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .j(j), .k(k),
    .ser_in(ser_in), .q(q), .qb(qb), .ser_out(ser_out),
    .illegal(illegal), .changed(changed)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Drive one cycle at the falling edge, queue its expectation, and settle after the rising edge.
  task automatic run_vec(input vec_t v);
    exp_t e;
    @(negedge clk);
    en = v.en; mode = v.m; d = v.d; j = v.j; k = v.k; ser_in = v.si;
    e.q = v.q; e.so = v.so; e.il = v.il; e.ch = v.ch;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic e, input logic [2:0] m,
                              input logic [7:0] dd, input logic [7:0] jj,
                              input logic [7:0] kk, input logic si,
                              input logic [7:0] eq, input logic so,
                              input logic il, input logic ch);
    vec_t v;
    v.en = e; v.m = m; v.d = dd; v.j = jj; v.k = kk; v.si = si;
    v.q = eq; v.so = so; v.il = il; v.ch = ch;
    return v;
  endfunction

  task automatic test_reset;
    vec_t v[3];
    exp_t e;
    rst = 1'b0; en = 1'b0; mode = 3'b000; d = '0; j = '0; k = '0; ser_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q, qb, ser_out, illegal, changed} !== {RV, ~RV, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got q=%h qb=%h so=%b il=%b ch=%b want q=%h qb=%h flags=0",
               q, qb, ser_out, illegal, changed, RV, ~RV);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) v[i] = mk(1'b0, 3'b001, 8'hFF, 8'h00, 8'h00, 1'b0, RV, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_vec(v[i]);
      e = sb.pop_front();
      checks++;
      if ({q, qb, ser_out, illegal, changed} !== {e.q, ~e.q, e.so, e.il, e.ch}) begin
        errors++;
        $display("FAIL en0_hold[%0d] got q=%h so=%b il=%b ch=%b want q=%h so=%b il=%b ch=%b",
                 i, q, ser_out, illegal, changed, e.q, e.so, e.il, e.ch);
      end
    end
  endtask

  task automatic test_d_jk_t;
    vec_t v[6];
    exp_t e;
    v[0] = mk(1'b1, 3'b001, 8'h3C, 8'h00, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    v[1] = mk(1'b1, 3'b010, 8'h00, 8'hF0, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1);
    v[2] = mk(1'b1, 3'b010, 8'h00, 8'hFF, 8'hFF, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
    v[3] = mk(1'b1, 3'b011, 8'h00, 8'h00, 8'h00, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
    v[4] = mk(1'b1, 3'b011, 8'hFF, 8'h00, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1);
    v[5] = mk(1'b1, 3'b000, 8'hFF, 8'hFF, 8'hFF, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_vec(v[i]);
      e = sb.pop_front();
      checks++;
      if ({q, qb, ser_out, illegal, changed} !== {e.q, ~e.q, e.so, e.il, e.ch}) begin
        errors++;
        $display("FAIL d_jk_t[%0d] got q=%h so=%b il=%b ch=%b want q=%h so=%b il=%b ch=%b",
                 i, q, ser_out, illegal, changed, e.q, e.so, e.il, e.ch);
      end
    end
  endtask

  task automatic test_sr_illegal;
    vec_t v[4];
    exp_t e;
    v[0] = mk(1'b1, 3'b001, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    v[1] = mk(1'b1, 3'b100, 8'h00, 8'h81, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    v[2] = mk(1'b1, 3'b000, 8'h00, 8'h81, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    v[3] = mk(1'b1, 3'b100, 8'h00, 8'h0C, 8'h80, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_vec(v[i]);
      e = sb.pop_front();
      checks++;
      if ({q, qb, ser_out, illegal, changed} !== {e.q, ~e.q, e.so, e.il, e.ch}) begin
        errors++;
        $display("FAIL sr[%0d] got q=%h so=%b il=%b ch=%b want q=%h so=%b il=%b ch=%b",
                 i, q, ser_out, illegal, changed, e.q, e.so, e.il, e.ch);
      end
    end
  endtask

  task automatic test_shift_rotate;
    vec_t v[6];
    exp_t e;
    logic [7:0] cur, start;
    v[0] = mk(1'b1, 3'b001, 8'h81, 8'h00, 8'h00, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    v[1] = mk(1'b1, 3'b101, 8'h00, 8'h00, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1);
    v[2] = mk(1'b1, 3'b110, 8'h00, 8'h00, 8'h00, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1);
    v[3] = mk(1'b1, 3'b111, 8'h00, 8'h00, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 1'b1);
    // ser_out holds through a non-shift mode and through en=0
    v[4] = mk(1'b1, 3'b001, 8'h03, 8'h00, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0);
    v[5] = mk(1'b0, 3'b101, 8'h00, 8'h00, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_vec(v[i]);
      e = sb.pop_front();
      checks++;
      if ({q, qb, ser_out, illegal, changed} !== {e.q, ~e.q, e.so, e.il, e.ch}) begin
        errors++;
        $display("FAIL shift[%0d] got q=%h so=%b il=%b ch=%b want q=%h so=%b il=%b ch=%b",
                 i, q, ser_out, illegal, changed, e.q, e.so, e.il, e.ch);
      end
    end
    start = 8'h03;
    cur   = start;
    for (int i = 0; i < 8; i++) begin
      vec_t r;
      r = mk(1'b1, 3'b111, 8'h00, 8'h00, 8'h00, 1'b1, {cur[6:0], cur[7]}, cur[7], 1'b0, 1'b1);
      cur = {cur[6:0], cur[7]};
      run_vec(r);
      e = sb.pop_front();
      checks++;
      if ({q, qb, ser_out, illegal, changed} !== {e.q, ~e.q, e.so, e.il, e.ch}) begin
        errors++;
        $display("FAIL rotate[%0d] got q=%h so=%b ch=%b want q=%h so=%b ch=%b",
                 i, q, ser_out, changed, e.q, e.so, e.ch);
      end
    end
    checks++;
    if (q !== start) begin
      errors++;
      $display("FAIL rotate8_return got q=%h want q=%h", q, start);
    end
  endtask

  task automatic test_async_reset;
    vec_t v;
    exp_t e;
    v = mk(1'b1, 3'b001, 8'h0F, 8'h00, 8'h00, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b1);
    run_vec(v);
    e = sb.pop_front();
    v = mk(1'b1, 3'b101, 8'h00, 8'h00, 8'h00, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b1);
    run_vec(v);
    e = sb.pop_front();
    checks++;
    if ({q, ser_out, changed} !== {e.q, e.so, e.ch}) begin
      errors++;
      $display("FAIL pre_reset_shift got q=%h so=%b ch=%b want q=%h so=%b ch=%b",
               q, ser_out, changed, e.q, e.so, e.ch);
    end
    // Next shift is already set up; drop reset between edges.
    @(negedge clk);
    ser_in = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({q, qb, ser_out, illegal, changed} !== {RV, ~RV, 3'b000}) begin
      errors++;
      $display("FAIL async_reset got q=%h qb=%h so=%b il=%b ch=%b want q=%h qb=%h flags=0",
               q, qb, ser_out, illegal, changed, RV, ~RV);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({q, ser_out, changed} !== {RV, 2'b00}) begin
      errors++;
      $display("FAIL reset_held_edge got q=%h so=%b ch=%b want q=%h so=0 ch=0", q, ser_out, changed, RV);
    end
    #2 rst = 1'b1;
    v = mk(1'b1, 3'b101, 8'h00, 8'h00, 8'h00, 1'b0, 8'h4A, 1'b1, 1'b0, 1'b1);
    run_vec(v);
    e = sb.pop_front();
    checks++;
    if ({q, qb, ser_out, illegal, changed} !== {e.q, ~e.q, e.so, e.il, e.ch}) begin
      errors++;
      $display("FAIL resume got q=%h so=%b il=%b ch=%b want q=%h so=%b il=%b ch=%b",
               q, ser_out, illegal, changed, e.q, e.so, e.il, e.ch);
    end
  endtask

  // Per-bit reference model for random traffic.
  function automatic exp_t model(input logic [7:0] cq, input logic cso, input logic e,
                                 input logic [2:0] m, input logic [7:0] dd,
                                 input logic [7:0] jj, input logic [7:0] kk, input logic si);
    exp_t r;
    logic [7:0] n;
    n = cq;
    r.so = cso;
    r.il = 1'b0;
    if (e) begin
      for (int i = 0; i < 8; i++) begin
        case (m)
          3'd1: n[i] = dd[i];
          3'd2: n[i] = (jj[i] && kk[i]) ? ~cq[i] : (jj[i] ? 1'b1 : (kk[i] ? 1'b0 : cq[i]));
          3'd3: n[i] = cq[i] ^ dd[i];
          3'd4: n[i] = (jj[i] && !kk[i]) ? 1'b1 : ((!jj[i] && kk[i]) ? 1'b0 : cq[i]);
          3'd5: n[i] = (i == 0) ? si : cq[i-1];
          3'd6: n[i] = (i == 7) ? si : cq[i+1];
          3'd7: n[i] = (i == 0) ? cq[7] : cq[i-1];
          default: n[i] = cq[i];
        endcase
        if (m == 3'd4 && jj[i] && kk[i]) r.il = 1'b1;
      end
      if (m == 3'd5 || m == 3'd7) r.so = cq[7];
      if (m == 3'd6) r.so = cq[0];
    end
    r.q  = n;
    r.ch = e && (n != cq);
    return r;
  endfunction

  task automatic test_back_to_back;
    vec_t v;
    exp_t e, p;
    logic [7:0] mq;
    logic       mso;
    v = mk(1'b1, 3'b001, 8'h5B, 8'h00, 8'h00, 1'b0, 8'h5B, 1'b1, 1'b0, 1'b1);
    run_vec(v);
    e = sb.pop_front();
    mq  = 8'h5B;
    mso = 1'b1;
    for (int i = 0; i < 60; i++) begin
      v.en = ($urandom_range(0, 4) != 0);
      v.m  = 3'($urandom_range(0, 7));
      v.d  = 8'($urandom);
      v.j  = 8'($urandom);
      v.k  = 8'($urandom);
      v.si = 1'($urandom);
      p = model(mq, mso, v.en, v.m, v.d, v.j, v.k, v.si);
      v.q = p.q; v.so = p.so; v.il = p.il; v.ch = p.ch;
      mq  = p.q;
      mso = p.so;
      run_vec(v);
      e = sb.pop_front();
      checks++;
      if ({q, qb, ser_out, illegal, changed} !== {e.q, ~e.q, e.so, e.il, e.ch}) begin
        errors++;
        $display("FAIL random[%0d] mode=%b en=%b got q=%h so=%b il=%b ch=%b want q=%h so=%b il=%b ch=%b",
                 i, v.m, v.en, q, ser_out, illegal, changed, e.q, e.so, e.il, e.ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_d_jk_t();
    test_sr_illegal();
    test_shift_rotate();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
